// File: rtl/i2c_master_arb.sv
// ---------------------------------------------------------------------------
// i2c_master_arb
//
// A single-byte I2C master engine that two local requesters share through a
// round-robin arbiter. For each transaction it drives START, the address byte
// {DEV_ADDR, rw}, the address ACK, one data byte, the data ACK/NACK and STOP.
// A read returns one byte, and the master NACKs that byte because it is the
// last one.
//
// Optional build macro: I2C_CLK_STRETCH_EN
//   When defined, the module gets an scl_in port. The bit-phase counter
//   freezes while SCL is released (scl=1) but the pad still reads low, so a
//   slave can stretch the clock.
//
// Ports
//   clk, rst_n        system clock; synchronous active-low reset
//   req0/rw0/wdata0   requester 0: request (held until done0), direction
//                     (1 = read), write byte
//   req1/rw1/wdata1   requester 1: same as requester 0
//   grant0/grant1     high while the matching requester owns the engine
//   done0/done1       one-cycle completion pulse
//   err               1 = NACK received; valid together with a done pulse
//   rdata             read byte; updated with the done pulse of a read
//   busy              high from grant until done
//   scl               SCL drive (1 = released)
//   scl_in            SCL pad sample (only when I2C_CLK_STRETCH_EN is defined)
//   sda_in            SDA pad sample
//   sda_out           SDA drive (1 = released)
// ---------------------------------------------------------------------------
module i2c_master_arb #(
  parameter int         SCL_PERIOD = 500,
  parameter int         SCL_HALF   = 250,
  parameter logic [6:0] DEV_ADDR   = 7'b1010001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       rw0,
  input  logic [7:0] wdata0,
  input  logic       req1,
  input  logic       rw1,
  input  logic [7:0] wdata1,
  output logic       grant0,
  output logic       grant1,
  output logic       done0,
  output logic       done1,
  output logic       err,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       scl,
`ifdef I2C_CLK_STRETCH_EN
  input  logic       scl_in,
`endif
  input  logic       sda_in,
  output logic       sda_out
);

  localparam int PW = (SCL_PERIOD > 1) ? $clog2(SCL_PERIOD) : 1;
  localparam logic [PW-1:0] PH_LAST     = PW'(SCL_PERIOD - 1);
  localparam logic [PW-1:0] PH_HALF     = PW'(SCL_HALF);
  localparam logic [PW-1:0] PH_LOW_MID  = PW'(SCL_HALF / 2);
  localparam logic [PW-1:0] PH_HIGH_MID = PW'(SCL_HALF + SCL_HALF / 2);

  typedef enum logic [3:0] {
    S_IDLE, S_ARB, S_START, S_ADDR, S_AACK, S_DATA, S_DACK, S_STOP, S_DONE
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_phase;
  logic [3:0]    r_bit;
  logic          r_last;     // requester served most recently
  logic          r_owner;    // current owner (0/1)
  logic          r_rw;
  logic [7:0]    r_wdata;
  logic [7:0]    r_shift;
  logic [7:0]    r_rdata;
  logic          r_grant0, r_grant1, r_done0, r_done1, r_err, r_busy;
  logic          r_scl, r_sda;

  logic          w_pick1;
  logic          w_hold;
  logic          w_step;
  logic          w_end;
  logic          w_low_mid;
  logic          w_high_mid;
  logic [7:0]    w_addr_byte;
  logic [2:0]    w_bit_idx;

  // When both requesters are pending, grant the one that was not served
  // last. r_last resets to 1, so requester 0 wins the first tie.
  assign w_pick1 = req1 && (!req0 || !r_last);

`ifdef I2C_CLK_STRETCH_EN
  // SCL is released but still reads low: a slave is stretching the clock.
  assign w_hold = r_scl && !scl_in;
`else
  assign w_hold = 1'b0;
`endif

  // Phase events are qualified with w_step so that a stretch cannot repeat
  // a sample or a drive event.
  assign w_step      = !w_hold;
  assign w_end       = w_step && (r_phase == PH_LAST);
  assign w_low_mid   = w_step && (r_phase == PH_LOW_MID);
  assign w_high_mid  = w_step && (r_phase == PH_HIGH_MID);
  assign w_addr_byte = {DEV_ADDR, r_rw};
  assign w_bit_idx   = ~r_bit[2:0];   // 7 - bit: MSB first

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_phase  <= '0;
      r_bit    <= '0;
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      r_rw     <= 1'b0;
      r_wdata  <= '0;
      r_shift  <= '0;
      r_rdata  <= '0;
      r_grant0 <= 1'b0;
      r_grant1 <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_scl    <= 1'b1;
      r_sda    <= 1'b1;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;

      // Bit-phase counter: it runs only while a bus transaction is in progress.
      if (r_state == S_IDLE || r_state == S_ARB) begin
        r_phase <= '0;
      end else if (w_step) begin
        r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + PW'(1);
      end

      // SCL is held high through START and while no transaction is active.
      // In every other state, each bit is a low half followed by a high half.
      case (r_state)
        S_IDLE, S_ARB, S_START, S_DONE: r_scl <= 1'b1;
        default:                        r_scl <= (r_phase >= PH_HALF);
      endcase

      case (r_state)
        S_IDLE: begin
          // Ignore requests while a done pulse is out. The finishing
          // requester still holds its request in that cycle.
          if (!r_done0 && !r_done1 && (req0 || req1)) begin
            r_state  <= S_ARB;
            r_owner  <= w_pick1;
            r_grant0 <= !w_pick1;
            r_grant1 <= w_pick1;
            r_busy   <= 1'b1;
            r_err    <= 1'b0;
          end
        end
        S_ARB: begin
          r_rw    <= r_owner ? rw1 : rw0;
          r_wdata <= r_owner ? wdata1 : wdata0;
          r_bit   <= '0;
          r_state <= S_START;
        end
        S_START: begin
          if (w_high_mid) r_sda <= 1'b0;
          if (w_end) begin
            r_bit   <= '0;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (w_low_mid) r_sda <= w_addr_byte[w_bit_idx];
          if (w_end) begin
            if (r_bit == 4'd7) begin
              r_bit   <= '0;
              r_state <= S_AACK;
            end else begin
              r_bit <= r_bit + 4'd1;
            end
          end
        end
        S_AACK: begin
          if (w_low_mid)  r_sda <= 1'b1;
          if (w_high_mid) r_err <= sda_in;
          if (w_end) begin
            r_bit   <= '0;
            r_state <= r_err ? S_STOP : S_DATA;
          end
        end
        S_DATA: begin
          if (w_low_mid)         r_sda   <= r_rw ? 1'b1 : r_wdata[w_bit_idx];
          if (w_high_mid && r_rw) r_shift <= {r_shift[6:0], sda_in};
          if (w_end) begin
            if (r_bit == 4'd7) begin
              r_bit   <= '0;
              r_state <= S_DACK;
            end else begin
              r_bit <= r_bit + 4'd1;
            end
          end
        end
        S_DACK: begin
          // A write releases SDA so the slave can ACK. A read drives NACK
          // because the byte just received is the last one.
          if (w_low_mid) r_sda <= 1'b1;
          if (w_high_mid && !r_rw && sda_in) r_err <= 1'b1;
          if (w_end) begin
            r_bit   <= '0;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_low_mid)  r_sda <= 1'b0;
          if (w_high_mid) r_sda <= 1'b1;
          if (w_end) begin
            r_bit   <= '0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          r_grant0 <= 1'b0;
          r_grant1 <= 1'b0;
          r_busy   <= 1'b0;
          r_done0  <= !r_owner;
          r_done1  <= r_owner;
          r_last   <= r_owner;
          if (r_rw && !r_err) r_rdata <= r_shift;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant0  = r_grant0;
  assign grant1  = r_grant1;
  assign done0   = r_done0;
  assign done1   = r_done1;
  assign err     = r_err;
  assign rdata   = r_rdata;
  assign busy    = r_busy;
  assign scl     = r_scl;
  assign sda_out = r_sda;

endmodule

// File: tb/tb_i2c_master_arb.sv
// Testbench for i2c_master_arb.
// - A behavioural slave watches SCL/SDA edges, records the bits on the bus
//   and ACKs or returns read data.
// - A reference model predicts latency, err and rdata from the
//   transaction-level rules.
// - The DUT uses a shortened bit period so that the whole run stays small.
module tb_i2c_master_arb;

  localparam int PER  = 100;
  localparam int HALF = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, rw0 = 1'b0, req1 = 1'b0, rw1 = 1'b0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       grant0, grant1, done0, done1, err, busy, scl, sda_out, sda_in;
  logic [7:0] rdata;

  int checks = 0;
  int errors = 0;

  // Behavioural slave and bus monitor state.
  logic       slave_sda = 1'b1;
  logic       stretch_act = 1'b0;
  logic       slv_ack_a = 1'b1, slv_ack_d = 1'b1, slv_stretch = 1'b0;
  logic [7:0] slv_rbyte = '0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  logic       mon_bits [0:31];
  int         mon_nbits = 0, mon_starts = 0;
  logic       mon_stop = 1'b0;
  int         st_state = 0, st_cnt = 0;
  int         both_grant = 0;

  wire sda_line = sda_out & slave_sda;
  wire scl_line = scl & ~stretch_act;
  assign sda_in = sda_line;
`ifdef I2C_CLK_STRETCH_EN
  logic scl_in;
  assign scl_in = scl_line;
`endif

  i2c_master_arb #(.SCL_PERIOD(PER), .SCL_HALF(HALF), .DEV_ADDR(7'b1010001)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .rw0(rw0), .wdata0(wdata0),
    .req1(req1), .rw1(rw1), .wdata1(wdata1),
    .grant0(grant0), .grant1(grant1), .done0(done0), .done1(done1),
    .err(err), .rdata(rdata), .busy(busy), .scl(scl),
`ifdef I2C_CLK_STRETCH_EN
    .scl_in(scl_in),
`endif
    .sda_in(sda_in), .sda_out(sda_out)
  );

  always #5 clk = ~clk;

  // The slave chooses what to drive for bit k (bits counted from START):
  //   k = 0..7   address byte
  //   k = 8      address ACK
  //   k = 9..16  data byte
  //   k = 17     data ACK
  function automatic logic slave_drive(input int k);
    logic is_rd;
    is_rd = mon_bits[7];
    if (k == 8) return !slv_ack_a;
    if (k >= 9 && k <= 16) return (is_rd && slv_ack_a) ? slv_rbyte[16-k] : 1'b1;
    if (k == 17) return (!is_rd && slv_ack_a) ? !slv_ack_d : 1'b1;
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    prev_scl <= scl_line;
    prev_sda <= sda_line;
    if (prev_scl === 1'b1 && scl_line === 1'b1 && prev_sda === 1'b1 && sda_line === 1'b0) begin
      mon_starts <= mon_starts + 1;
      mon_nbits  <= 0;
      mon_stop   <= 1'b0;
      slave_sda  <= 1'b1;
    end else if (prev_scl === 1'b1 && scl_line === 1'b1 && prev_sda === 1'b0 && sda_line === 1'b1) begin
      mon_stop <= 1'b1;
    end else if (prev_scl === 1'b0 && scl_line === 1'b1) begin
      if (mon_nbits < 32) mon_bits[mon_nbits] <= sda_line;
      mon_nbits <= mon_nbits + 1;
    end else if (prev_scl === 1'b1 && scl_line === 1'b0) begin
      slave_sda <= slave_drive(mon_nbits);
      if (mon_nbits == 2 && slv_stretch) begin
        stretch_act <= 1'b1;
        st_state    <= 1;
      end
    end
    // Hold SCL low for 1000 clocks once the master has released it.
    if (st_state == 1 && scl === 1'b1) begin
      st_state <= 2;
      st_cnt   <= 1000;
    end else if (st_state == 2) begin
      st_cnt <= st_cnt - 1;
      if (st_cnt == 1) begin
        stretch_act <= 1'b0;
        st_state    <= 0;
      end
    end
  end

  always @(negedge clk) if (grant0 === 1'b1 && grant1 === 1'b1) both_grant <= both_grant + 1;

  function automatic logic [7:0] mon_byte(input int base);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = mon_bits[base+i];
    return b;
  endfunction

  // Model state and per-transaction observations.
  logic [7:0] exp_rdata = '0;
  logic       ob_done, ob_err;
  logic [7:0] ob_rdata;
  int         ob_lat, ob_starts;

  task automatic apply_reset();
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_rdata = '0;
    @(negedge clk);
  endtask

  // Runs one transaction for requester 'who' and records what happens.
  task automatic do_txn(input int who, input logic rw, input logic [7:0] wd,
                        input logic ack_a, input logic ack_d, input logic [7:0] rb,
                        input logic stretch);
    int n;
    int s0;
    logic granted;
    slv_ack_a = ack_a; slv_ack_d = ack_d; slv_rbyte = rb; slv_stretch = stretch;
    s0 = mon_starts;
    if (who == 0) begin rw0 = rw; wdata0 = wd; req0 = 1'b1; end
    else          begin rw1 = rw; wdata1 = wd; req1 = 1'b1; end
    granted = 1'b0;
    n = 0;
    while (n < 10 && !granted) begin
      @(negedge clk); n++;
      granted = (who == 0) ? grant0 : grant1;
    end
    ob_lat = 0; ob_done = 1'b0; ob_err = 1'b0; ob_rdata = '0;
    if (granted) begin
      while (ob_lat < 40 * PER + 2000 && !ob_done) begin
        @(negedge clk); ob_lat++;
        ob_done = (who == 0) ? done0 : done1;
        ob_err = err; ob_rdata = rdata;
      end
    end
    if (who == 0) req0 = 1'b0; else req1 = 1'b0;
    slv_stretch = 1'b0;
    ob_starts = mon_starts - s0;
    $display("txn who=%0d rw=%0d wdata=%h lat=%0d done=%0b err=%0b rdata=%h",
             who, rw, wd, ob_lat, ob_done, ob_err, ob_rdata);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({scl, sda_out, grant0, grant1, done0, done1, err, busy} !== 8'b1100_0000) begin
      errors++;
      $display("FAIL reset_ctl: got %b expected 11000000",
               {scl, sda_out, grant0, grant1, done0, done1, err, busy});
    end
    checks++;
    if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
    apply_reset();
  endtask

  task automatic test_write();
    do_txn(0, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0);
    checks++;
    if (!ob_done || ob_lat != 20 * PER + 2) begin
      errors++; $display("FAIL write_latency: got %0d done=%0b expected %0d", ob_lat, ob_done, 20 * PER + 2);
    end
    checks++;
    if (ob_err !== 1'b0) begin errors++; $display("FAIL write_err: got %b expected 0", ob_err); end
    checks++;
    if (mon_byte(0) !== 8'hA2 || mon_byte(9) !== 8'hA5) begin
      errors++; $display("FAIL write_bus: got addr %h data %h expected A2 A5", mon_byte(0), mon_byte(9));
    end
    checks++;
    if (ob_starts != 1 || !mon_stop || mon_nbits != 19 || mon_bits[8] !== 1'b0 || mon_bits[17] !== 1'b0) begin
      errors++;
      $display("FAIL write_frame: got starts=%0d stop=%0b bits=%0d ack=%b%b expected 1 1 19 00",
               ob_starts, mon_stop, mon_nbits, mon_bits[8], mon_bits[17]);
    end
  endtask

  task automatic test_read();
    exp_rdata = 8'hCA;
    do_txn(1, 1'b1, 8'h00, 1'b1, 1'b1, 8'hCA, 1'b0);
    checks++;
    if (!ob_done || ob_lat != 20 * PER + 2) begin
      errors++; $display("FAIL read_latency: got %0d done=%0b expected %0d", ob_lat, ob_done, 20 * PER + 2);
    end
    checks++;
    if (ob_rdata !== exp_rdata || ob_err !== 1'b0) begin
      errors++; $display("FAIL read_data: got %h err=%b expected %h err=0", ob_rdata, ob_err, exp_rdata);
    end
    checks++;
    if (mon_byte(0) !== 8'hA3 || mon_bits[17] !== 1'b1) begin
      errors++; $display("FAIL read_bus: got addr %h nack=%b expected A3 1", mon_byte(0), mon_bits[17]);
    end
  endtask

  task automatic test_addr_nack();
    do_txn(0, 1'b0, 8'($urandom), 1'b0, 1'b1, 8'h00, 1'b0);
    checks++;
    if (!ob_done || ob_lat != 11 * PER + 2) begin
      errors++; $display("FAIL nack_latency: got %0d done=%0b expected %0d", ob_lat, ob_done, 11 * PER + 2);
    end
    checks++;
    if (ob_err !== 1'b1 || ob_rdata !== exp_rdata) begin
      errors++; $display("FAIL nack_result: got err=%b rdata=%h expected 1 %h", ob_err, ob_rdata, exp_rdata);
    end
    checks++;
    if (mon_nbits != 10 || !mon_stop) begin
      errors++; $display("FAIL nack_frame: got bits=%0d stop=%0b expected 10 1", mon_nbits, mon_stop);
    end
  endtask

  task automatic test_arbitration();
    int order[$];
    int exp_order[$];
    int m_last;
    int n;
    int w;
    logic [1:0] pend;
    logic       err_seen;
    apply_reset();
    m_last = 1;
    err_seen = 1'b0;
    slv_ack_a = 1'b1; slv_ack_d = 1'b1;
    for (int r = 0; r < 2; r++) begin
      // Model: serve every pending requester, preferring the one not served last.
      pend = 2'b11;
      while (pend != 2'b00) begin
        w = (pend == 2'b11) ? ((m_last == 0) ? 1 : 0) : (pend[1] ? 1 : 0);
        exp_order.push_back(w);
        m_last = w;
        pend[w] = 1'b0;
      end
      rw0 = 1'b0; rw1 = 1'b0; wdata0 = 8'($urandom); wdata1 = 8'($urandom);
      req0 = 1'b1; req1 = 1'b1;
      n = 0;
      while ((req0 || req1) && n < 3 * (20 * PER + 10)) begin
        @(negedge clk); n++;
        if (done0) begin order.push_back(0); req0 = 1'b0; err_seen |= err; end
        if (done1) begin order.push_back(1); req1 = 1'b0; err_seen |= err; end
      end
      req0 = 1'b0; req1 = 1'b0;
      $display("txn arbitration round %0d served %0d requests", r, order.size());
      @(negedge clk);
    end
    checks++;
    if (order.size() != exp_order.size()) begin
      errors++; $display("FAIL arb_count: got %0d expected %0d", order.size(), exp_order.size());
    end else begin
      for (int i = 0; i < order.size(); i++) begin
        checks++;
        if (order[i] != exp_order[i]) begin
          errors++; $display("FAIL arb_order[%0d]: got %0d expected %0d", i, order[i], exp_order[i]);
        end
      end
    end
    checks++;
    if (both_grant != 0 || err_seen !== 1'b0) begin
      errors++; $display("FAIL arb_exclusive: got overlap=%0d err=%b expected 0 0", both_grant, err_seen);
    end
    checks++;
    if (mon_byte(9) !== ((exp_order[exp_order.size()-1] == 0) ? wdata0 : wdata1)) begin
      errors++; $display("FAIL arb_data: got %h expected %h", mon_byte(9),
                         (exp_order[exp_order.size()-1] == 0) ? wdata0 : wdata1);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int dcount;
    logic [7:0] wd;
    slv_ack_a = 1'b1; slv_ack_d = 1'b1;
    rw0 = 1'b0; wdata0 = 8'($urandom); req0 = 1'b1;
    n = 0;
    while (!grant0 && n < 10) begin @(negedge clk); n++; end
    n = 0;
    while (mon_nbits != 12 && n < 30 * PER) begin @(negedge clk); n++; end
    checks++;
    if (mon_nbits != 12) begin errors++; $display("FAIL rstmid_reach: got bits=%0d expected 12", mon_nbits); end
    rst_n = 1'b0; req0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_rdata = '0;
    checks++;
    if ({scl, sda_out, busy, grant0} !== 4'b1100) begin
      errors++; $display("FAIL rstmid_state: got %b expected 1100", {scl, sda_out, busy, grant0});
    end
    dcount = 0;
    repeat (3 * PER) begin @(negedge clk); if (done0 || done1) dcount++; end
    checks++;
    if (dcount != 0) begin errors++; $display("FAIL rstmid_done: got %0d pulses expected 0", dcount); end
    wd = 8'($urandom);
    do_txn(0, 1'b0, wd, 1'b1, 1'b1, 8'h00, 1'b0);
    checks++;
    if (!ob_done || ob_lat != 20 * PER + 2 || ob_err !== 1'b0 || mon_byte(9) !== wd) begin
      errors++;
      $display("FAIL rstmid_after: got lat=%0d err=%b data=%h expected %0d 0 %h",
               ob_lat, ob_err, mon_byte(9), 20 * PER + 2, wd);
    end
  endtask

  task automatic test_random();
    int who;
    logic rw, aa, ad;
    logic [7:0] wd, rb;
    int e_lat;
    logic e_err;
    for (int t = 0; t < 6; t++) begin
      who = $urandom_range(0, 1);
      rw = 1'($urandom_range(0, 1));
      wd = 8'($urandom); rb = 8'($urandom);
      aa = ($urandom_range(0, 3) != 0);
      ad = ($urandom_range(0, 3) != 0);
      e_lat = (aa ? 20 : 11) * PER + 2;
      e_err = !aa || (!rw && !ad);
      if (rw && aa) exp_rdata = rb;
      do_txn(who, rw, wd, aa, ad, rb, 1'b0);
      checks++;
      if (!ob_done || ob_lat != e_lat) begin
        errors++; $display("FAIL rand%0d_latency: got %0d done=%0b expected %0d", t, ob_lat, ob_done, e_lat);
      end
      checks++;
      if (ob_err !== e_err || ob_rdata !== exp_rdata) begin
        errors++; $display("FAIL rand%0d_result: got err=%b rdata=%h expected %b %h",
                           t, ob_err, ob_rdata, e_err, exp_rdata);
      end
      checks++;
      if (mon_byte(0) !== {7'b1010001, rw} || mon_nbits != (aa ? 19 : 10)) begin
        errors++; $display("FAIL rand%0d_bus: got addr=%h bits=%0d expected %h %0d",
                           t, mon_byte(0), mon_nbits, {7'b1010001, rw}, aa ? 19 : 10);
      end
      if (aa && !rw) begin
        checks++;
        if (mon_byte(9) !== wd) begin
          errors++; $display("FAIL rand%0d_wdata: got %h expected %h", t, mon_byte(9), wd);
        end
      end
    end
  endtask

`ifdef I2C_CLK_STRETCH_EN
  task automatic test_stretch();
    logic [7:0] wd;
    wd = 8'($urandom);
    do_txn(0, 1'b0, wd, 1'b1, 1'b1, 8'h00, 1'b1);
    checks++;
    if (!ob_done || ob_lat != 20 * PER + 2 + 1000) begin
      errors++; $display("FAIL stretch_latency: got %0d expected %0d", ob_lat, 20 * PER + 2 + 1000);
    end
    checks++;
    if (mon_byte(0) !== 8'hA2 || mon_byte(9) !== wd || ob_err !== 1'b0) begin
      errors++; $display("FAIL stretch_bus: got %h %h err=%b expected A2 %h 0",
                         mon_byte(0), mon_byte(9), ob_err, wd);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_arbitration();
    test_reset_mid();
    test_random();
`ifdef I2C_CLK_STRETCH_EN
    test_stretch();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
